// File: rtl/axi_portal_pkg.sv
// Shared encodings and state types for the AXI portal arbiter.
package axi_portal_pkg;

    localparam int unsigned PORTAL_OFFSET_W = 12;
    localparam int unsigned RESP_W          = 2;
    localparam int unsigned PORTAL_IDX_W    = 3;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_REQ,
        RD_RESP
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DATA,
        WR_REQ,
        WR_RESP
    } wr_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; a grant is held until the access is accepted.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_done,
    output logic [1:0] o_gnt_c
);

    logic r_prio;   // requester index that wins a tie
    logic r_lock;   // a grant is outstanding and must be held
    logic r_owner;  // requester holding the outstanding grant

    // Held owner first, then tie-break by priority, else the lone requester
    always_comb begin
        o_gnt_c = 2'b00;
        if (r_lock) begin
            o_gnt_c[r_owner] = i_req[r_owner];
        end else if (&i_req) begin
            o_gnt_c[r_prio] = 1'b1;
        end else begin
            o_gnt_c = i_req;
        end
    end

    // Lock on a stalled grant; hand priority to the other requester after each accept
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prio  <= 1'b0;
            r_lock  <= 1'b0;
            r_owner <= 1'b0;
        end else if (|o_gnt_c) begin
            if (i_done) begin
                r_lock <= 1'b0;
                r_prio <= ~o_gnt_c[1];
            end else begin
                r_lock  <= 1'b1;
                r_owner <= o_gnt_c[1];
            end
        end else if (r_lock) begin
            r_lock <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_portal_arbiter.sv
// AXI slave front end that splits bursts into single-word portal register accesses.
module axi_portal_arbiter
    import axi_portal_pkg::*;
#(
    parameter int unsigned NUM_PORTALS  = 4,
    parameter int unsigned PORTAL_SHIFT = 13,
    parameter int unsigned ID_W         = 12,
    parameter int unsigned LEN_W        = 4,
    parameter int unsigned DATA_W       = 32
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          ar_valid,
    output logic                          ar_ready,
    input  logic [31:0]                   ar_addr,
    input  logic [ID_W-1:0]               ar_id,
    input  logic [LEN_W-1:0]              ar_len,
    input  logic                          aw_valid,
    output logic                          aw_ready,
    input  logic [31:0]                   aw_addr,
    input  logic [ID_W-1:0]               aw_id,
    input  logic [LEN_W-1:0]              aw_len,
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic [DATA_W-1:0]             w_data,
    input  logic                          w_last,
    output logic                          r_valid,
    input  logic                          r_ready,
    output logic [DATA_W-1:0]             r_data,
    output logic [ID_W-1:0]               r_id,
    output logic [1:0]                    r_resp,
    output logic                          r_last,
    output logic                          b_valid,
    input  logic                          b_ready,
    output logic [ID_W-1:0]               b_id,
    output logic [1:0]                    b_resp,
    output logic [NUM_PORTALS-1:0]        pt_req_valid,
    input  logic [NUM_PORTALS-1:0]        pt_req_ready,
    output logic                          pt_req_write,
    output logic [11:0]                   pt_req_addr,
    output logic [DATA_W-1:0]             pt_req_wdata,
    input  logic [NUM_PORTALS*DATA_W-1:0] pt_rsp_rdata,
    input  logic [NUM_PORTALS-1:0]        pt_irq,
    output logic                          interrupt
);

    localparam int unsigned IDX_W = PORTAL_IDX_W;
    localparam int unsigned CMP_W = IDX_W + 1;

    rd_state_e                  r_rd_state, w_rd_next;
    logic [ID_W-1:0]            r_rd_id;
    logic [LEN_W-1:0]           r_rd_cnt;
    logic [PORTAL_OFFSET_W-1:0] r_rd_off;
    logic [IDX_W-1:0]           r_rd_idx;
    logic [DATA_W-1:0]          r_rd_data;
    logic [RESP_W-1:0]          r_rd_resp;

    wr_state_e                  r_wr_state, w_wr_next;
    logic [ID_W-1:0]            r_wr_id;
    logic [LEN_W-1:0]           r_wr_cnt;
    logic [PORTAL_OFFSET_W-1:0] r_wr_off;
    logic [IDX_W-1:0]           r_wr_idx;
    logic [DATA_W-1:0]          r_wr_data;
    logic                       r_wr_err;

    logic                       r_interrupt;
    logic                       w_rd_inrange, w_wr_inrange;
    logic [1:0]                 w_req, w_gnt;
    logic [IDX_W-1:0]           w_sel_idx;
    logic [DATA_W-1:0]          w_rd_rdata;
    logic                       w_accept, w_rd_acc, w_wr_acc;
    logic                       w_unused;

    assign w_rd_inrange = {1'b0, r_rd_idx} < CMP_W'(NUM_PORTALS);
    assign w_wr_inrange = {1'b0, r_wr_idx} < CMP_W'(NUM_PORTALS);

    // Out-of-range engines never request the bus
    assign w_req = {(r_wr_state == WR_REQ) && w_wr_inrange,
                    (r_rd_state == RD_REQ) && w_rd_inrange};

    rr_arb2 u_arb (
        .i_clk   (CLK),
        .i_rst_n (nRST),
        .i_req   (w_req),
        .i_done  (w_accept),
        .o_gnt_c (w_gnt)
    );

    assign w_sel_idx = w_gnt[1] ? r_wr_idx : r_wr_idx & '0 | r_rd_idx;

    // One-hot portal select for the granted engine and read-data slice for the read engine
    always_comb begin
        pt_req_valid = '0;
        w_rd_rdata   = '0;
        for (int i = 0; i < NUM_PORTALS; i++) begin
            if ((|w_gnt) && (IDX_W'(i) == w_sel_idx)) pt_req_valid[i] = 1'b1;
            if (IDX_W'(i) == r_rd_idx) w_rd_rdata = pt_rsp_rdata[i*DATA_W +: DATA_W];
        end
    end

    assign w_accept     = |(pt_req_valid & pt_req_ready);
    assign w_rd_acc     = w_accept & w_gnt[0];
    assign w_wr_acc     = w_accept & w_gnt[1];
    assign pt_req_write = w_gnt[1];
    assign pt_req_addr  = w_gnt[1] ? r_wr_off : r_rd_off;
    assign pt_req_wdata = r_wr_data;

    assign r_data    = r_rd_data;
    assign r_id      = r_rd_id;
    assign r_resp    = r_rd_resp;
    assign b_id      = r_wr_id;
    assign interrupt = r_interrupt;
    assign w_unused  = ^{ar_addr, aw_addr};

    // Read engine state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_rd_state <= RD_IDLE;
        else       r_rd_state <= w_rd_next;
    end

    // Read engine next state and handshake outputs
    always_comb begin
        w_rd_next = r_rd_state;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        r_last    = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                ar_ready = 1'b1;
                if (ar_valid) w_rd_next = RD_REQ;
            end
            RD_REQ: begin
                if (!w_rd_inrange || w_rd_acc) w_rd_next = RD_RESP;
            end
            RD_RESP: begin
                r_valid = 1'b1;
                r_last  = (r_rd_cnt == '0);
                if (r_ready) w_rd_next = (r_rd_cnt == '0) ? RD_IDLE : RD_REQ;
            end
            default: w_rd_next = RD_IDLE;
        endcase
    end

    // Read engine burst bookkeeping and response capture
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rd_id   <= '0;
            r_rd_cnt  <= '0;
            r_rd_off  <= '0;
            r_rd_idx  <= '0;
            r_rd_data <= '0;
            r_rd_resp <= RESP_OKAY;
        end else begin
            if (r_rd_state == RD_IDLE && ar_valid) begin
                r_rd_id  <= ar_id;
                r_rd_cnt <= ar_len;
                r_rd_off <= ar_addr[PORTAL_OFFSET_W-1:0];
                r_rd_idx <= ar_addr[PORTAL_SHIFT +: IDX_W];
            end
            if (r_rd_state == RD_REQ) begin
                if (!w_rd_inrange) begin
                    r_rd_data <= '0;
                    r_rd_resp <= RESP_SLVERR;
                end else if (w_rd_acc) begin
                    r_rd_data <= w_rd_rdata;
                    r_rd_resp <= RESP_OKAY;
                end
            end
            if (r_rd_state == RD_RESP && r_ready && r_rd_cnt != '0) begin
                r_rd_cnt <= r_rd_cnt - LEN_W'(1);
                r_rd_off <= r_rd_off + PORTAL_OFFSET_W'(4);
            end
        end
    end

    // Write engine state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_wr_state <= WR_IDLE;
        else       r_wr_state <= w_wr_next;
    end

    // Write engine next state and handshake outputs
    always_comb begin
        w_wr_next = r_wr_state;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        b_valid   = 1'b0;
        b_resp    = RESP_OKAY;
        case (r_wr_state)
            WR_IDLE: begin
                aw_ready = 1'b1;
                if (aw_valid) w_wr_next = WR_DATA;
            end
            WR_DATA: begin
                w_ready = 1'b1;
                if (w_valid) w_wr_next = WR_REQ;
            end
            WR_REQ: begin
                if (!w_wr_inrange || w_wr_acc)
                    w_wr_next = (r_wr_cnt == '0) ? WR_RESP : WR_DATA;
            end
            WR_RESP: begin
                b_valid = 1'b1;
                b_resp  = r_wr_err ? RESP_SLVERR : RESP_OKAY;
                if (b_ready) w_wr_next = WR_IDLE;
            end
            default: w_wr_next = WR_IDLE;
        endcase
    end

    // Write engine burst bookkeeping, beat latch and sticky error
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wr_id   <= '0;
            r_wr_cnt  <= '0;
            r_wr_off  <= '0;
            r_wr_idx  <= '0;
            r_wr_data <= '0;
            r_wr_err  <= 1'b0;
        end else begin
            if (r_wr_state == WR_IDLE && aw_valid) begin
                r_wr_id  <= aw_id;
                r_wr_cnt <= aw_len;
                r_wr_off <= aw_addr[PORTAL_OFFSET_W-1:0];
                r_wr_idx <= aw_addr[PORTAL_SHIFT +: IDX_W];
            end
            if (r_wr_state == WR_DATA && w_valid) begin
                r_wr_data <= w_data;
                if (w_last != (r_wr_cnt == '0)) r_wr_err <= 1'b1;
            end
            if (r_wr_state == WR_REQ) begin
                if (!w_wr_inrange) r_wr_err <= 1'b1;
                if ((!w_wr_inrange || w_wr_acc) && r_wr_cnt != '0) begin
                    r_wr_cnt <= r_wr_cnt - LEN_W'(1);
                    r_wr_off <= r_wr_off + PORTAL_OFFSET_W'(4);
                end
            end
            if (r_wr_state == WR_RESP && b_ready) r_wr_err <= 1'b0;
        end
    end

    // Registered interrupt aggregate
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_interrupt <= 1'b0;
        else       r_interrupt <= |pt_irq;
    end

endmodule

// File: tb/tb_axi_portal_arbiter.sv
// Directed bench for axi_portal_arbiter with a bus-access monitor.
module tb_axi_portal_arbiter;

    localparam int unsigned NP   = 4;
    localparam int unsigned IDW  = 12;
    localparam int unsigned LENW = 4;
    localparam int unsigned DW   = 32;

    logic            CLK = 1'b0;
    logic            nRST;
    logic            ar_valid, ar_ready, aw_valid, aw_ready, w_valid, w_ready, w_last;
    logic [31:0]     ar_addr, aw_addr;
    logic [IDW-1:0]  ar_id, aw_id, r_id, b_id;
    logic [LENW-1:0] ar_len, aw_len;
    logic [DW-1:0]   w_data, r_data, pt_req_wdata;
    logic            r_valid, r_ready, r_last, b_valid, b_ready;
    logic [1:0]      r_resp, b_resp;
    logic [NP-1:0]   pt_req_valid, pt_req_ready, pt_irq;
    logic            pt_req_write, interrupt;
    logic [11:0]     pt_req_addr;
    logic [NP*DW-1:0] pt_rsp_rdata;
    logic [31:0]     pdata [NP];

    assign pt_rsp_rdata = {pdata[3], pdata[2], pdata[1], pdata[0]};

    axi_portal_arbiter #(
        .NUM_PORTALS(NP), .PORTAL_SHIFT(13), .ID_W(IDW), .LEN_W(LENW), .DATA_W(DW)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id), .ar_len(ar_len),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id), .aw_len(aw_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_id(r_id), .r_resp(r_resp), .r_last(r_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
        .pt_req_valid(pt_req_valid), .pt_req_ready(pt_req_ready), .pt_req_write(pt_req_write),
        .pt_req_addr(pt_req_addr), .pt_req_wdata(pt_req_wdata), .pt_rsp_rdata(pt_rsp_rdata),
        .pt_irq(pt_irq), .interrupt(interrupt)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Accepted portal accesses, sampled mid-cycle before the accepting edge
    logic        acc_wr    [$];
    logic [11:0] acc_addr  [$];
    logic [31:0] acc_wdata [$];
    int          acc_port  [$];
    int          bad_onehot = 0;

    always @(negedge CLK) begin
        if (nRST) begin
            if (!$onehot0(pt_req_valid)) bad_onehot++;
            if (|(pt_req_valid & pt_req_ready)) begin
                acc_wr.push_back(pt_req_write);
                acc_addr.push_back(pt_req_addr);
                acc_wdata.push_back(pt_req_wdata);
                for (int i = 0; i < NP; i++) if (pt_req_valid[i]) acc_port.push_back(i);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_q();
        acc_wr.delete();
        acc_addr.delete();
        acc_wdata.delete();
        acc_port.delete();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [11:0] id, input logic [3:0] len,
                           input logic [31:0] exp_data, input logic [1:0] exp_rsp, input string tag);
        int   beats;
        logic hs_ar;
        beats = 0;
        ar_addr = addr; ar_id = id; ar_len = len; ar_valid = 1'b1; r_ready = 1'b1;
        for (int c = 0; c < 80 && beats <= int'(len); c++) begin
            hs_ar = ar_valid & ar_ready;
            if (r_valid) begin
                beats++;
                chk({tag, "_beat"}, {r_data, r_id, r_resp, r_last},
                    {exp_data, id, exp_rsp, 1'(beats == int'(len) + 1)});
            end
            step();
            if (hs_ar) ar_valid = 1'b0;
        end
        chk({tag, "_beats"}, 64'(beats), 64'(len) + 64'd1);
        ar_valid = 1'b0; r_ready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [11:0] id, input logic [3:0] len,
                            input logic bad_last, output logic [1:0] resp, output logic [11:0] bid,
                            output logic seen);
        int   beat;
        logic hs_aw, hs_w, hs_b;
        beat = 0; seen = 1'b0; resp = 2'b11; bid = '0;
        aw_addr = addr; aw_id = id; aw_len = len; aw_valid = 1'b1;
        w_valid = 1'b1; w_data = 32'hA000_0000;
        w_last = bad_last ? 1'b0 : (len == 4'd0);
        b_ready = 1'b1;
        for (int c = 0; c < 80 && !seen; c++) begin
            hs_aw = aw_valid & aw_ready;
            hs_w  = w_valid & w_ready;
            hs_b  = b_valid & b_ready;
            if (hs_b) begin resp = b_resp; bid = b_id; end
            step();
            if (hs_aw) aw_valid = 1'b0;
            if (hs_w) begin
                beat++;
                w_data = 32'hA000_0000 + 32'(beat);
                w_last = (beat == int'(len));
                if (beat > int'(len)) w_valid = 1'b0;
            end
            if (hs_b) seen = 1'b1;
        end
        aw_valid = 1'b0; w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b0;
    endtask

    logic [11:0] burst_off [4];
    logic [1:0]  wresp;
    logic [11:0] wbid;
    logic        wseen, bseen, hs_ar, hs_aw, hs_w, hs_b;
    int          wbeat, rbeats;
    logic [3:0]  seq;

    initial begin
        nRST = 1'b0;
        ar_valid = 0; ar_addr = 0; ar_id = 0; ar_len = 0;
        aw_valid = 0; aw_addr = 0; aw_id = 0; aw_len = 0;
        w_valid = 0; w_data = 0; w_last = 0; r_ready = 0; b_ready = 0;
        pt_req_ready = '0; pt_irq = '0;
        pdata[0] = 32'h1111_0000; pdata[1] = 32'hDEAD_BEEF;
        pdata[2] = 32'h2222_0000; pdata[3] = 32'h3333_0003;
        burst_off = '{12'hFFC, 12'h000, 12'h004, 12'h008};

        #1;
        chk("reset_state", {r_valid, r_last, b_valid, interrupt, pt_req_valid, ar_ready, aw_ready},
            {1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1});
        step(); step();
        nRST = 1'b1;
        pt_req_ready = 4'hF;

        // Single read, portal 1 offset 8: bus access in cycle 1, r_valid in cycle 2
        clr_q();
        ar_addr = 32'h0000_2008; ar_id = 12'h0A5; ar_len = 4'd0; ar_valid = 1'b1;
        chk("rd1_ar_ready", 64'(ar_ready), 64'd1);
        step();
        ar_valid = 1'b0;
        chk("rd1_cycle1_bus", {pt_req_valid, pt_req_write, pt_req_addr, r_valid},
            {4'b0010, 1'b0, 12'h008, 1'b0});
        step();
        chk("rd1_cycle2_r", {r_valid, r_data, r_last, r_resp, r_id},
            {1'b1, 32'hDEAD_BEEF, 1'b1, 2'b00, 12'h0A5});
        r_ready = 1'b1;
        step();
        chk("rd1_done", 64'(r_valid), 64'd0);
        r_ready = 1'b0;

        // Read burst wrapping the 12-bit offset
        clr_q();
        do_read(32'h0000_0FFC, 12'h03C, 4'd3, 32'h1111_0000, 2'b00, "rd_burst");
        chk("rd_burst_accesses", 64'(acc_addr.size()), 64'd4);
        for (int i = 0; i < 4 && i < acc_addr.size(); i++)
            chk("rd_burst_access", {acc_wr[i], acc_addr[i], 8'(acc_port[i])},
                {1'b0, burst_off[i], 8'd0});

        // Write burst len=1 to portal 2
        clr_q();
        do_write(32'h0000_4000, 12'h123, 4'd1, 1'b0, wresp, wbid, wseen);
        chk("wr_burst_b", {wseen, wresp, wbid}, {1'b1, 2'b00, 12'h123});
        chk("wr_burst_accesses", 64'(acc_addr.size()), 64'd2);
        for (int i = 0; i < 2 && i < acc_addr.size(); i++)
            chk("wr_burst_access", {acc_wr[i], acc_addr[i], acc_wdata[i], 8'(acc_port[i])},
                {1'b1, 12'(4 * i), 32'hA000_0000 + 32'(i), 8'd2});

        // Out-of-range portal index 5
        clr_q();
        do_write(32'h0000_A000, 12'h055, 4'd0, 1'b0, wresp, wbid, wseen);
        chk("wr_oor_b", {wseen, wresp, wbid}, {1'b1, 2'b10, 12'h055});
        do_read(32'h0000_A000, 12'h066, 4'd0, 32'h0, 2'b10, "rd_oor");
        chk("oor_no_access", 64'(acc_addr.size()), 64'd0);

        // w_last on the wrong beat sets a sticky error that clears on b
        clr_q();
        do_write(32'h0000_0010, 12'h0E1, 4'd0, 1'b1, wresp, wbid, wseen);
        chk("wr_badlast_b", {wseen, wresp}, {1'b1, 2'b10});
        chk("wr_badlast_access", 64'(acc_addr.size()), 64'd1);
        do_write(32'h0000_2020, 12'h0E2, 4'd0, 1'b0, wresp, wbid, wseen);
        chk("wr_after_err_b", {wseen, wresp, wbid}, {1'b1, 2'b00, 12'h0E2});

        // Concurrent read and write bursts, stalled then released
        clr_q();
        pt_req_ready = 4'h0;
        ar_addr = 32'h0; ar_id = 12'h0C1; ar_len = 4'd1; ar_valid = 1'b1; r_ready = 1'b1;
        aw_addr = 32'h0000_6000; aw_id = 12'h0C2; aw_len = 4'd1; aw_valid = 1'b1;
        w_valid = 1'b1; w_data = 32'hB000_0000; w_last = 1'b0; b_ready = 1'b1;
        wbeat = 0; rbeats = 0; bseen = 1'b0;
        for (int c = 0; c < 80 && !(bseen && rbeats == 2); c++) begin
            if (c == 6) begin
                chk("conc_stall_grant", {pt_req_valid, pt_req_write}, {4'b0001, 1'b0});
                pt_req_ready = 4'hF;
            end
            hs_ar = ar_valid & ar_ready;
            hs_aw = aw_valid & aw_ready;
            hs_w  = w_valid & w_ready;
            hs_b  = b_valid & b_ready;
            if (r_valid) rbeats++;
            step();
            if (hs_ar) ar_valid = 1'b0;
            if (hs_aw) aw_valid = 1'b0;
            if (hs_w) begin
                wbeat++;
                w_data = 32'hB000_0000 + 32'(wbeat);
                w_last = (wbeat == 1);
                if (wbeat > 1) w_valid = 1'b0;
            end
            if (hs_b) bseen = 1'b1;
        end
        ar_valid = 0; aw_valid = 0; w_valid = 0; w_last = 0; r_ready = 0; b_ready = 0;
        chk("conc_done", {bseen, 8'(rbeats)}, {1'b1, 8'd2});
        chk("conc_accesses", 64'(acc_wr.size()), 64'd4);
        seq = 4'b1111;
        for (int i = 0; i < 4 && i < acc_wr.size(); i++) seq[3 - i] = acc_wr[i];
        chk("conc_alternation", 64'(seq), 64'(4'b0101));
        for (int i = 0; i < 4 && i < acc_addr.size(); i++)
            chk("conc_access", {acc_addr[i], 8'(acc_port[i])},
                {12'(4 * (i / 2)), (i % 2 == 1) ? 8'd3 : 8'd0});

        // Interrupt is registered one cycle after pt_irq
        pt_irq = 4'b0100;
        chk("irq_not_yet", 64'(interrupt), 64'd0);
        step();
        chk("irq_set", 64'(interrupt), 64'd1);

        // Reset in the middle of a read burst
        ar_addr = 32'h0000_2000; ar_id = 12'h00D; ar_len = 4'd3; ar_valid = 1'b1; r_ready = 1'b0;
        for (int c = 0; c < 20 && !r_valid; c++) begin
            hs_ar = ar_valid & ar_ready;
            step();
            if (hs_ar) ar_valid = 1'b0;
        end
        ar_valid = 1'b0;
        chk("rst_pre_rvalid", {r_valid, r_data, r_id}, {1'b1, 32'hDEAD_BEEF, 12'h00D});
        #2;
        nRST = 1'b0;
        #1;
        chk("rst_async_outputs",
            {r_valid, r_last, r_data, r_resp, r_id, b_valid, pt_req_valid, interrupt},
            {1'b0, 1'b0, 32'h0, 2'b00, 12'h000, 1'b0, 4'b0000, 1'b0});
        pt_irq = '0;
        step(); step();
        nRST = 1'b1;
        clr_q();
        do_read(32'h0000_6010, 12'h007, 4'd0, 32'h3333_0003, 2'b00, "rd_post_rst");
        chk("post_rst_access", {64'(acc_addr.size()), 12'(acc_addr.size() > 0 ? acc_addr[0] : 12'hFFF)},
            {64'd1, 12'h010});

        chk("onehot_or_zero", 64'(bad_onehot), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
